// File: rtl/hazard5_ahb_sram.sv
// hazard5_ahb_sram: zero-wait-state AHB-Lite slave in front of a single-port
// synchronous SRAM. A one-entry write buffer lets a write data phase overlap a
// read address phase, and buffered or in-flight write bytes are forwarded to
// reads of the same word.
// Optional feature macro: HAZARD5_AHB_SRAM_RANGE_CHECK_EN (ERROR response for
// haddr >= 4*DEPTH instead of aliasing).
module hazard5_ahb_sram #(
  parameter int unsigned W_ADDR = 32,
  parameter int unsigned DEPTH  = 4096,
  localparam int unsigned W_SRAM = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ahbls_hready_resp,
  input  logic              ahbls_hready,
  output logic              ahbls_hresp,
  input  logic [W_ADDR-1:0] ahbls_haddr,
  input  logic              ahbls_hwrite,
  input  logic [1:0]        ahbls_htrans,
  input  logic [2:0]        ahbls_hsize,
  input  logic [31:0]       ahbls_hwdata,
  output logic [31:0]       ahbls_hrdata,
  output logic [W_SRAM-1:0] sram_addr,
  output logic              sram_cs,
  output logic [3:0]        sram_we,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata
);

  // Little-endian byte lane mask; misaligned low address bits are ignored.
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] a);
    case (size)
      3'd0:    lane_mask = 4'b0001 << a;
      3'd1:    lane_mask = 4'b0011 << {a[1], 1'b0};
      default: lane_mask = 4'hf;
    endcase
  endfunction

  logic              aph_valid, aph_in_range, aph_ok, aph_read, aph_write;
  logic [W_SRAM-1:0] aph_addr;
  logic [3:0]        aph_mask;
  logic              unused_bits;

  logic              dph_read_q, dph_read_d;
  logic              dph_write_q, dph_write_d;
  logic [W_SRAM-1:0] dph_addr_q, dph_addr_d;
  logic [3:0]        dph_mask_q, dph_mask_d;
  logic [3:0]        fwd_mask_q, fwd_mask_d;
  logic [31:0]       fwd_data_q, fwd_data_d;
  logic              wbuf_valid_q, wbuf_valid_d;
  logic [W_SRAM-1:0] wbuf_addr_q, wbuf_addr_d;
  logic [3:0]        wbuf_mask_q, wbuf_mask_d;
  logic [31:0]       wbuf_data_q, wbuf_data_d;
  logic              wdph_lost;

  assign aph_valid   = ahbls_htrans[1] & ahbls_hready;
  assign aph_addr    = ahbls_haddr[W_SRAM+1:2];
  assign aph_mask    = lane_mask(ahbls_hsize, ahbls_haddr[1:0]);
  assign unused_bits = ^{ahbls_htrans[0], ahbls_haddr[W_ADDR-1:W_SRAM+2]};

`ifdef HAZARD5_AHB_SRAM_RANGE_CHECK_EN
  typedef enum logic [1:0] {ST_OK = 2'd0, ST_ERR1 = 2'd1, ST_ERR2 = 2'd2} state_t;

  state_t state_q, state_d;
  logic   hready_resp_q, hready_resp_d;
  logic   hresp_q, hresp_d;

  assign aph_in_range = ~|ahbls_haddr[W_ADDR-1:W_SRAM+2];

  // Two-cycle ERROR response sequencing for out-of-range transfers.
  always_comb begin
    state_d       = state_q;
    hready_resp_d = 1'b1;
    hresp_d       = 1'b0;
    case (state_q)
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = (aph_valid & ~aph_in_range) ? ST_ERR1 : ST_OK;
    endcase
    hready_resp_d = (state_d != ST_ERR1);
    hresp_d       = (state_d != ST_OK);
  end

  // Response state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_OK;
      hready_resp_q <= 1'b1;
      hresp_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      hready_resp_q <= hready_resp_d;
      hresp_q       <= hresp_d;
    end
  end

  assign ahbls_hready_resp = hready_resp_q;
  assign ahbls_hresp       = hresp_q;
`else
  assign aph_in_range      = 1'b1;
  assign ahbls_hready_resp = 1'b1;
  assign ahbls_hresp       = 1'b0;
`endif

  assign aph_ok    = aph_valid & aph_in_range;
  assign aph_read  = aph_ok & ~ahbls_hwrite;
  assign aph_write = aph_ok & ahbls_hwrite;

  // SRAM port arbitration (read aph > buffer drain > direct write), buffer
  // capture, data-phase tracking and forwarding capture for reads.
  always_comb begin
    sram_cs      = 1'b0;
    sram_we      = 4'h0;
    sram_addr    = aph_addr;
    sram_wdata   = ahbls_hwdata;
    dph_read_d   = aph_read;
    dph_write_d  = aph_write;
    dph_addr_d   = dph_addr_q;
    dph_mask_d   = dph_mask_q;
    fwd_mask_d   = 4'h0;
    fwd_data_d   = fwd_data_q;
    wbuf_valid_d = wbuf_valid_q;
    wbuf_addr_d  = wbuf_addr_q;
    wbuf_mask_d  = wbuf_mask_q;
    wbuf_data_d  = wbuf_data_q;
    wdph_lost    = dph_write_q & (aph_read | wbuf_valid_q);

    if (aph_ok) begin
      dph_addr_d = aph_addr;
      dph_mask_d = aph_mask;
    end

    if (aph_read) begin
      sram_cs = 1'b1;
    end else if (wbuf_valid_q) begin
      sram_cs      = 1'b1;
      sram_we      = wbuf_mask_q;
      sram_addr    = wbuf_addr_q;
      sram_wdata   = wbuf_data_q;
      wbuf_valid_d = 1'b0;
    end else if (dph_write_q) begin
      sram_cs   = 1'b1;
      sram_we   = dph_mask_q;
      sram_addr = dph_addr_q;
    end

    if (wdph_lost) begin
      wbuf_valid_d = 1'b1;
      wbuf_addr_d  = dph_addr_q;
      wbuf_mask_d  = dph_mask_q;
      wbuf_data_d  = ahbls_hwdata;
    end

    // The concurrent write data phase is newer than the buffer, so it wins.
    if (aph_read) begin
      for (int i = 0; i < 4; i++) begin
        if (dph_write_q && dph_addr_q == aph_addr && dph_mask_q[i]) begin
          fwd_mask_d[i]        = 1'b1;
          fwd_data_d[8*i +: 8] = ahbls_hwdata[8*i +: 8];
        end else if (wbuf_valid_q && wbuf_addr_q == aph_addr && wbuf_mask_q[i]) begin
          fwd_mask_d[i]        = 1'b1;
          fwd_data_d[8*i +: 8] = wbuf_data_q[8*i +: 8];
        end
      end
    end
  end

  // Data-phase, forwarding and write-buffer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dph_read_q   <= 1'b0;
      dph_write_q  <= 1'b0;
      dph_addr_q   <= '0;
      dph_mask_q   <= 4'h0;
      fwd_mask_q   <= 4'h0;
      fwd_data_q   <= 32'h0;
      wbuf_valid_q <= 1'b0;
      wbuf_addr_q  <= '0;
      wbuf_mask_q  <= 4'h0;
      wbuf_data_q  <= 32'h0;
    end else begin
      dph_read_q   <= dph_read_d;
      dph_write_q  <= dph_write_d;
      dph_addr_q   <= dph_addr_d;
      dph_mask_q   <= dph_mask_d;
      fwd_mask_q   <= fwd_mask_d;
      fwd_data_q   <= fwd_data_d;
      wbuf_valid_q <= wbuf_valid_d;
      wbuf_addr_q  <= wbuf_addr_d;
      wbuf_mask_q  <= wbuf_mask_d;
      wbuf_data_q  <= wbuf_data_d;
    end
  end

  // Read data: SRAM word with forwarded bytes substituted, zero when idle.
  always_comb begin
    ahbls_hrdata = 32'h0;
    if (dph_read_q) begin
      for (int i = 0; i < 4; i++) begin
        ahbls_hrdata[8*i +: 8] = fwd_mask_q[i] ? fwd_data_q[8*i +: 8] : sram_rdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_hazard5_ahb_sram.sv
// Self-checking bench for hazard5_ahb_sram: directed vector table, reset and
// aliasing/range sequences, then random traffic against a bus-order memory model.
module tb_hazard5_ahb_sram;

  localparam int unsigned DEPTH  = 4096;
  localparam int unsigned W_SRAM = $clog2(DEPTH);
  localparam logic [1:0]  IDLE   = 2'b00;
  localparam logic [1:0]  BUSY   = 2'b01;
  localparam logic [1:0]  NSEQ   = 2'b10;

  logic              clk, rst;
  wire               hready_resp;
  wire               hready;
  wire               hresp;
  logic [31:0]       haddr;
  logic              hwrite;
  logic [1:0]        htrans;
  logic [2:0]        hsize;
  logic [31:0]       hwdata;
  wire  [31:0]       hrdata;
  wire  [W_SRAM-1:0] sram_addr;
  wire               sram_cs;
  wire  [3:0]        sram_we;
  wire  [31:0]       sram_wdata;
  logic [31:0]       sram_rdata;

  assign hready = hready_resp;

  hazard5_ahb_sram #(.W_ADDR(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .ahbls_hready_resp(hready_resp), .ahbls_hready(hready), .ahbls_hresp(hresp),
    .ahbls_haddr(haddr), .ahbls_hwrite(hwrite), .ahbls_htrans(htrans),
    .ahbls_hsize(hsize), .ahbls_hwdata(hwdata), .ahbls_hrdata(hrdata),
    .sram_addr(sram_addr), .sram_cs(sram_cs), .sram_we(sram_we),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous SRAM model; mem_clr zeroes it once at start of test.
  logic        mem_clr;
  logic [31:0] sram_mem [DEPTH];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < int'(DEPTH); i++) sram_mem[i] <= 32'h0;
      sram_rdata <= 32'h0;
    end else if (sram_cs) begin
      if (sram_we != 4'h0) begin
        for (int b = 0; b < 4; b++) begin
          if (sram_we[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
        end
      end else begin
        sram_rdata <= sram_mem[sram_addr];
      end
    end
  end

  // Reference: memory as seen by the bus in transfer order.
  logic [31:0] ref_mem [DEPTH];
  int          n_vec, n_err;
  logic        prev_rd, prev_wr;
  logic [31:0] prev_wd, prev_exp;

  typedef struct {
    logic [1:0]  tr;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  sz;
    logic [31:0] wd;
    logic [31:0] exp;
    logic        ecs;
    logic [3:0]  ewe;
  } vec_t;

  vec_t tbl [19];

  function automatic int word_idx(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  function automatic logic [3:0] lanes(input logic [2:0] sz, input logic [31:0] a);
    int off;
    off = int'(a % 4);
    if (sz == 3'd0) return 4'(1 << off);
    if (sz == 3'd1) return 4'(3 << (2 * (off / 2)));
    return 4'hf;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic ref_write(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    logic [3:0] m;
    int         idx;
    m   = lanes(sz, a);
    idx = word_idx(a);
    for (int b = 0; b < 4; b++) begin
      if (m[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
    end
  endtask

  // One bus cycle: check the previous data phase, present a new address phase.
  task automatic step(input logic [1:0] tr, input logic wr, input logic [31:0] addr,
                      input logic [2:0] sz, input logic [31:0] wd, input logic [31:0] exp,
                      input logic chk_port, input logic ecs, input logic [3:0] ewe);
    @(negedge clk);
    if (prev_rd) chk("hrdata", hrdata, prev_exp);
    else         chk("hrdata_idle", hrdata, 32'h0);
    htrans = tr;
    hwrite = wr;
    haddr  = addr;
    hsize  = sz;
    hwdata = prev_wr ? prev_wd : $urandom;
    #1;
    chk("hready_resp", 32'(hready_resp), 32'h1);
    chk("hresp", 32'(hresp), 32'h0);
    if (chk_port) begin
      chk("sram_cs", 32'(sram_cs), 32'(ecs));
      chk("sram_we", 32'(sram_we), 32'(ewe));
    end
    prev_rd  = tr[1] & ~wr;
    prev_wr  = tr[1] & wr;
    prev_wd  = wd;
    prev_exp = exp;
    if (prev_wr) ref_write(addr, sz, wd);
  endtask

  task automatic idle_step(input logic chk_port, input logic ecs, input logic [3:0] ewe);
    step(IDLE, 1'b0, 32'h0, 3'd0, 32'h0, 32'h0, chk_port, ecs, ewe);
  endtask

  initial begin
    logic [1:0]  tr;
    logic        wr;
    logic [2:0]  sz;
    logic [31:0] a, hi, wd;

    tbl[0]  = '{NSEQ, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 32'h0,        1'b0, 4'h0};
    tbl[1]  = '{IDLE, 1'b0, 32'h0,  3'd0, 32'h0,        32'h0,        1'b1, 4'hf};
    tbl[2]  = '{NSEQ, 1'b0, 32'h10, 3'd2, 32'h0,        32'hDEADBEEF, 1'b1, 4'h0};
    tbl[3]  = '{IDLE, 1'b0, 32'h0,  3'd0, 32'h0,        32'h0,        1'b0, 4'h0};
    tbl[4]  = '{NSEQ, 1'b1, 32'h20, 3'd2, 32'h11223344, 32'h0,        1'b0, 4'h0};
    tbl[5]  = '{NSEQ, 1'b0, 32'h20, 3'd2, 32'h0,        32'h11223344, 1'b1, 4'h0};
    tbl[6]  = '{IDLE, 1'b0, 32'h0,  3'd0, 32'h0,        32'h0,        1'b1, 4'hf};
    tbl[7]  = '{NSEQ, 1'b1, 32'h33, 3'd0, 32'hAB000000, 32'h0,        1'b0, 4'h0};
    tbl[8]  = '{NSEQ, 1'b0, 32'h32, 3'd1, 32'h0,        32'hAB000000, 1'b1, 4'h0};
    tbl[9]  = '{IDLE, 1'b0, 32'h0,  3'd0, 32'h0,        32'h0,        1'b1, 4'h8};
    tbl[10] = '{NSEQ, 1'b1, 32'h40, 3'd2, 32'hCAFEF00D, 32'h0,        1'b0, 4'h0};
    tbl[11] = '{NSEQ, 1'b0, 32'h44, 3'd2, 32'h0,        32'h0,        1'b1, 4'h0};
    tbl[12] = '{NSEQ, 1'b0, 32'h48, 3'd2, 32'h0,        32'h0,        1'b1, 4'h0};
    tbl[13] = '{NSEQ, 1'b1, 32'h4C, 3'd2, 32'h0BADC0DE, 32'h0,        1'b1, 4'hf};
    tbl[14] = '{IDLE, 1'b0, 32'h0,  3'd0, 32'h0,        32'h0,        1'b1, 4'hf};
    tbl[15] = '{NSEQ, 1'b0, 32'h40, 3'd2, 32'h0,        32'hCAFEF00D, 1'b1, 4'h0};
    tbl[16] = '{NSEQ, 1'b0, 32'h4C, 3'd2, 32'h0,        32'h0BADC0DE, 1'b1, 4'h0};
    tbl[17] = '{BUSY, 1'b0, 32'h10, 3'd2, 32'h0,        32'h0,        1'b0, 4'h0};
    tbl[18] = '{IDLE, 1'b0, 32'h0,  3'd0, 32'h0,        32'h0,        1'b0, 4'h0};

    n_vec = 0; n_err = 0;
    prev_rd = 1'b0; prev_wr = 1'b0; prev_wd = 32'h0; prev_exp = 32'h0;
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = 32'h0;
    rst = 1'b1; mem_clr = 1'b1;
    htrans = IDLE; hwrite = 1'b0; haddr = 32'h0; hsize = 3'd0; hwdata = 32'h0;
    repeat (3) @(negedge clk);
    mem_clr = 1'b0;
    chk("rst_hready_resp", 32'(hready_resp), 32'h1);
    chk("rst_hresp", 32'(hresp), 32'h0);
    chk("rst_hrdata", hrdata, 32'h0);
    chk("rst_sram_cs", 32'(sram_cs), 32'h0);
    chk("rst_sram_we", 32'(sram_we), 32'h0);
    rst = 1'b0;

    // Directed table: forwarding, buffering and port arbitration per cycle.
    for (int i = 0; i < 19; i++) begin
      step(tbl[i].tr, tbl[i].wr, tbl[i].addr, tbl[i].sz, tbl[i].wd, tbl[i].exp,
           1'b1, tbl[i].ecs, tbl[i].ewe);
    end

`ifndef HAZARD5_AHB_SRAM_RANGE_CHECK_EN
    // Upper address bits alias onto the SRAM.
    step(NSEQ, 1'b1, 32'h80000050, 3'd2, 32'h5A5A1234, 32'h0, 1'b0, 1'b0, 4'h0);
    step(NSEQ, 1'b0, 32'h00000050, 3'd2, 32'h0, 32'h5A5A1234, 1'b0, 1'b0, 4'h0);
    step(NSEQ, 1'b0, 32'h00004010, 3'd2, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 4'h0);
    idle_step(1'b0, 1'b0, 4'h0);
`endif

    // Reset with a write sitting in the buffer drops that write.
    step(NSEQ, 1'b1, 32'h60, 3'd2, 32'h12345678, 32'h0, 1'b0, 1'b0, 4'h0);
    idle_step(1'b1, 1'b1, 4'hf);
    step(NSEQ, 1'b1, 32'h60, 3'd2, 32'hAAAAAAAA, 32'h0, 1'b0, 1'b0, 4'h0);
    step(NSEQ, 1'b0, 32'h64, 3'd2, 32'h0, 32'h0, 1'b1, 1'b1, 4'h0);
    @(negedge clk);
    htrans = IDLE; hwrite = 1'b0; rst = 1'b1;
    #1;
    chk("rstmid_sram_cs", 32'(sram_cs), 32'h0);
    chk("rstmid_sram_we", 32'(sram_we), 32'h0);
    chk("rstmid_hrdata", hrdata, 32'h0);
    chk("rstmid_hready_resp", 32'(hready_resp), 32'h1);
    prev_rd = 1'b0; prev_wr = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ref_mem[word_idx(32'h60)] = 32'h12345678;
    step(NSEQ, 1'b0, 32'h60, 3'd2, 32'h0, 32'h12345678, 1'b1, 1'b1, 4'h0);
    idle_step(1'b1, 1'b0, 4'h0);

    // Random traffic against the bus-order reference memory.
    for (int n = 0; n < 600; n++) begin
      tr = 2'($urandom_range(0, 3));
      wr = 1'($urandom_range(0, 1));
      sz = 3'($urandom_range(0, 2));
      wd = $urandom;
`ifdef HAZARD5_AHB_SRAM_RANGE_CHECK_EN
      hi = 32'h0;
`else
      hi = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFFC000) : 32'h0;
`endif
      a = hi | 32'h400 | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      step(tr, wr, a, sz, wd, ref_mem[word_idx(a)], 1'b0, 1'b0, 4'h0);
    end
    idle_step(1'b0, 1'b0, 4'h0);
    idle_step(1'b0, 1'b0, 4'h0);

`ifdef HAZARD5_AHB_SRAM_RANGE_CHECK_EN
    // Out-of-range read: two-cycle ERROR, no SRAM access, then OKAY again.
    @(negedge clk);
    htrans = NSEQ; hwrite = 1'b0; haddr = 32'h4000; hsize = 3'd2;
    #1;
    chk("err_aph_sram_cs", 32'(sram_cs), 32'h0);
    @(negedge clk);
    htrans = IDLE;
    #1;
    chk("err1_hready_resp", 32'(hready_resp), 32'h0);
    chk("err1_hresp", 32'(hresp), 32'h1);
    chk("err1_sram_cs", 32'(sram_cs), 32'h0);
    chk("err1_hrdata", hrdata, 32'h0);
    @(negedge clk);
    #1;
    chk("err2_hready_resp", 32'(hready_resp), 32'h1);
    chk("err2_hresp", 32'(hresp), 32'h1);
    prev_rd = 1'b0; prev_wr = 1'b0;
    step(NSEQ, 1'b0, 32'h10, 3'd2, 32'h0, ref_mem[word_idx(32'h10)], 1'b1, 1'b1, 4'h0);
    idle_step(1'b0, 1'b0, 4'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
